// File: rtl/wshbn_slave_ram_burst_if.sv
// Wishbone B4 classic bus bundle between the cache controller master and the RAM slave.
// Signal names keep the slave-side _I/_O suffixes so both ends read the same as the datasheet.
interface wshbn_slave_ram_burst_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   ADR_I;
    logic [DW-1:0]   DAT_I;
    logic [DW/8-1:0] SEL_I;
    logic            WE_I;
    logic            STB_I;
    logic            CYC_I;
    logic [2:0]      CTI_I;
    logic [DW-1:0]   DAT_O;
    logic            ACK_O;
    logic            ERR_O;

    // Handshake: a request is CYC_I & STB_I held until the slave answers with a
    // one-cycle ACK_O or ERR_O; CTI_I = 010 at an ACK keeps the burst going.
    modport master (
        output ADR_I, DAT_I, SEL_I, WE_I, STB_I, CYC_I, CTI_I,
        input  DAT_O, ACK_O, ERR_O
    );

    modport slave (
        input  ADR_I, DAT_I, SEL_I, WE_I, STB_I, CYC_I, CTI_I,
        output DAT_O, ACK_O, ERR_O
    );
endinterface

// File: rtl/wshbn_slave_ram_burst.sv
// Wishbone B4 classic slave over a synchronous single-port RAM with configurable wait
// states, byte-lane writes, out-of-range ERR_O and incrementing-burst streaming.
module wshbn_slave_ram_burst #(
    parameter int    AW          = 32,
    parameter int    DW          = 32,
    parameter int    DEPTH       = 1024,
    parameter int    WAIT_STATES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    wshbn_slave_ram_burst_if.slave  wb,
    output logic [1:0]              dbg_state
);
    localparam int          NB      = DW / 8;
    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [3:0]  WS      = 4'(WAIT_STATES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;

    logic [1:0]    state;
    logic [3:0]    wait_cnt;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data;
    logic [AW-1:0] rd_addr;
    logic          req;
    logic          in_range;
    logic          rd_in_range;
    logic          ack;
    logic          err;
    logic          burst_go;

    assign req      = wb.CYC_I & wb.STB_I;
    assign in_range = {1'b0, addr_q} < DEPTH_W;
    assign ack      = (state == ST_XFER) && req && in_range;
    assign err      = (state == ST_XFER) && req && !in_range;
    assign burst_go = ack && (wb.CTI_I == 3'b010);

    // Look one word ahead so the registered read lands in the cycle that ACKs it.
    always_comb begin
        rd_addr = addr_q;
        case (state)
            ST_IDLE: rd_addr = wb.ADR_I;
            ST_XFER: if (burst_go) rd_addr = addr_q + 1'b1;
            default: rd_addr = addr_q;
        endcase
    end

    assign rd_in_range = {1'b0, rd_addr} < DEPTH_W;

    // A write whose ACK coincides with a reset edge is dropped.
    always_ff @(posedge CLK_I) begin
        if (rd_in_range) rd_data <= mem[rd_addr[IW-1:0]];
        if (ack && we_q && !RST_I) begin
            for (int i = 0; i < NB; i++) begin
                if (wb.SEL_I[i]) mem[addr_q[IW-1:0]][8*i +: 8] <= wb.DAT_I[8*i +: 8];
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            addr_q   <= '0;
            we_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        addr_q   <= wb.ADR_I;
                        we_q     <= wb.WE_I;
                        wait_cnt <= WS;
                        state    <= (WS == 4'd0) ? ST_XFER : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!req) begin
                        state    <= ST_IDLE;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                        if (wait_cnt == 4'd1) state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (burst_go) addr_q <= addr_q + 1'b1;
                    else          state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign wb.ACK_O  = ack;
    assign wb.ERR_O  = err;
    assign wb.DAT_O  = ack ? rd_data : '0;
    assign dbg_state = state;
endmodule

// File: tb/tb_wshbn_slave_ram_burst.sv
// Bench for wshbn_slave_ram_burst: three slaves (WS=0/DEPTH=16, WS=1/DEPTH=1024,
// WS=3/DEPTH=64) share one driven bus; a word-array model predicts every beat.
module tb_wshbn_slave_ram_burst;
    logic        clk;
    logic        rst;
    int          dut_sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel_s;
    logic        we_s;
    logic        stb;
    logic        cyc;
    logic [2:0]  cti;
    logic        ack;
    logic        err;
    logic [31:0] rdat;
    logic [1:0]  st0, st1, st2;

    int          errors = 0;
    int          checks = 0;
    int          ws_t[3]    = '{0, 1, 3};
    int          depth_t[3] = '{16, 1024, 64};
    logic [31:0] model [3][1024];
    logic [31:0] bd [16];
    logic [3:0]  bs [16];
    logic [31:0] last_rd;

    wshbn_slave_ram_burst_if #(.AW(32), .DW(32)) bus0 (), bus1 (), bus2 ();

    assign bus0.ADR_I = adr;  assign bus1.ADR_I = adr;  assign bus2.ADR_I = adr;
    assign bus0.DAT_I = wdat; assign bus1.DAT_I = wdat; assign bus2.DAT_I = wdat;
    assign bus0.SEL_I = sel_s; assign bus1.SEL_I = sel_s; assign bus2.SEL_I = sel_s;
    assign bus0.WE_I  = we_s; assign bus1.WE_I  = we_s; assign bus2.WE_I  = we_s;
    assign bus0.STB_I = stb;  assign bus1.STB_I = stb;  assign bus2.STB_I = stb;
    assign bus0.CTI_I = cti;  assign bus1.CTI_I = cti;  assign bus2.CTI_I = cti;
    assign bus0.CYC_I = cyc && (dut_sel == 0);
    assign bus1.CYC_I = cyc && (dut_sel == 1);
    assign bus2.CYC_I = cyc && (dut_sel == 2);

    assign ack  = (dut_sel == 0) ? bus0.ACK_O : (dut_sel == 1) ? bus1.ACK_O : bus2.ACK_O;
    assign err  = (dut_sel == 0) ? bus0.ERR_O : (dut_sel == 1) ? bus1.ERR_O : bus2.ERR_O;
    assign rdat = (dut_sel == 0) ? bus0.DAT_O : (dut_sel == 1) ? bus1.DAT_O : bus2.DAT_O;

    wshbn_slave_ram_burst #(.AW(32), .DW(32), .DEPTH(16), .WAIT_STATES(0), .INIT_FILE("")) u_dut0 (
        .CLK_I(clk), .RST_I(rst), .wb(bus0), .dbg_state(st0));
    wshbn_slave_ram_burst #(.AW(32), .DW(32), .DEPTH(1024), .WAIT_STATES(1), .INIT_FILE("")) u_dut1 (
        .CLK_I(clk), .RST_I(rst), .wb(bus1), .dbg_state(st1));
    wshbn_slave_ram_burst #(.AW(32), .DW(32), .DEPTH(64), .WAIT_STATES(3), .INIT_FILE("")) u_dut2 (
        .CLK_I(clk), .RST_I(rst), .wb(bus2), .dbg_state(st2));

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        assert (!(bus0.ACK_O && bus0.ERR_O) && !(bus1.ACK_O && bus1.ERR_O) && !(bus2.ACK_O && bus2.ERR_O))
        else begin
            errors++;
            $error("FAIL ack_err_overlap: observed ACK_O and ERR_O both high, expected never together");
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle of n beats from bd/bs and checks it against the word model.
    task automatic run_xfer(input int d, input logic w, input logic [31:0] a0, input int n);
        logic [31:0] a;
        logic        oor;
        logic [31:0] m;
        dut_sel = d; cyc = 1'b1; stb = 1'b1; we_s = w; adr = a0;
        wdat = bd[0]; sel_s = bs[0];
        cti = (n == 1) ? 3'b000 : 3'b010;
        for (int c = 0; c <= ws_t[d]; c++) begin
            @(negedge clk);
            check("latency_quiet", {ack, err, rdat}, 64'd0);
            step();
        end
        for (int k = 0; k < n; k++) begin
            a   = a0 + k;
            oor = (a >= depth_t[d]);
            if (k > 0) begin
                adr = a; wdat = bd[k]; sel_s = bs[k];
                cti = (k == n - 1) ? 3'b111 : 3'b010;
            end
            @(negedge clk);
            m = model[d][a[9:0]];
            check("beat_ack", ack, !oor);
            check("beat_err", err, oor);
            if (!oor && !w) begin
                check("read_data", rdat, m);
                last_rd = rdat;
            end
            if (!oor && w) begin
                for (int i = 0; i < 4; i++) begin
                    if (bs[k][i]) model[d][a[9:0]][8*i +: 8] = bd[k][8*i +: 8];
                end
            end
            step();
            if (oor) break;
        end
        cyc = 1'b0; stb = 1'b0; cti = 3'b000; we_s = 1'b0;
        @(negedge clk);
        check("post_idle", {ack, err, rdat}, 64'd0);
        step();
    endtask

    initial begin
        int          d;
        int          n;
        logic        w;
        logic [31:0] a;
        logic [31:0] saved;

        rst = 1'b1; dut_sel = 0; cyc = 1'b0; stb = 1'b0; we_s = 1'b0;
        adr = '0; wdat = '0; sel_s = '0; cti = 3'b000; last_rd = '0;
        repeat (3) step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            dut_sel = k;
            @(negedge clk);
            check("reset_outputs", {ack, err, rdat}, 64'd0);
        end
        check("reset_state", {st0, st1, st2}, 64'd0);
        step();

        // Fill every word later read, using 16-beat write bursts.
        for (int k = 0; k < 3; k++) begin
            for (int base = 0; base < 64 && base < depth_t[k]; base += 16) begin
                for (int i = 0; i < 16; i++) begin
                    bd[i] = $urandom; bs[i] = 4'hF;
                end
                run_xfer(k, 1'b1, base, 16);
            end
        end

        // WAIT_STATES=1 write then read
        bd[0] = 32'hDEADBEEF; bs[0] = 4'hF;
        run_xfer(1, 1'b1, 32'd5, 1);
        run_xfer(1, 1'b0, 32'd5, 1);
        check("deadbeef", last_rd, 32'hDEADBEEF);

        // Byte lanes
        bd[0] = 32'h11223344; bs[0] = 4'hF;
        run_xfer(1, 1'b1, 32'd7, 1);
        bd[0] = 32'hAABBCCDD; bs[0] = 4'b0101;
        run_xfer(1, 1'b1, 32'd7, 1);
        run_xfer(1, 1'b0, 32'd7, 1);
        check("byte_lanes", last_rd, 32'h11BB33DD);

        // WAIT_STATES=0 four-beat read burst
        run_xfer(0, 1'b0, 32'd8, 4);

        // Burst running off the end of a 16-word RAM, then a classic out-of-range write
        run_xfer(0, 1'b0, 32'd14, 3);
        check("idle_after_err", st0, 2'd0);
        saved = model[0][4];
        bd[0] = 32'hCAFEF00D; bs[0] = 4'hF;
        run_xfer(0, 1'b1, 32'd20, 1);
        run_xfer(0, 1'b0, 32'd4, 1);
        check("oor_write_no_alias", last_rd, saved);

        // Abort a write during WAIT (WAIT_STATES=3)
        dut_sel = 2; cyc = 1'b1; stb = 1'b1; we_s = 1'b1; adr = 32'd9;
        wdat = 32'h0BADF00D; sel_s = 4'hF; cti = 3'b000;
        repeat (2) begin
            @(negedge clk);
            check("abort_wait", {ack, err}, 64'd0);
            step();
        end
        cyc = 1'b0; stb = 1'b0; we_s = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("abort_quiet", {ack, err}, 64'd0);
            step();
        end
        run_xfer(2, 1'b0, 32'd9, 1);

        // Reset during the ACK cycle of a read and then of a write (WAIT_STATES=1)
        for (int k = 0; k < 2; k++) begin
            dut_sel = 1; cyc = 1'b1; stb = 1'b1; we_s = (k == 1); adr = 32'd6;
            wdat = 32'h12345678; sel_s = 4'hF; cti = 3'b000;
            step();
            step();
            rst = 1'b1;
            @(negedge clk);
            check("ack_before_reset", ack, 1'b1);
            step();
            rst = 1'b0;
            @(negedge clk);
            check("outputs_after_reset", {ack, err, rdat}, 64'd0);
            cyc = 1'b0; stb = 1'b0; we_s = 1'b0;
            step();
            step();
        end
        run_xfer(1, 1'b0, 32'd6, 1);

        // Back-to-back classic reads (WAIT_STATES=0): one idle cycle between ACKs
        dut_sel = 0; cyc = 1'b1; stb = 1'b1; we_s = 1'b0; adr = 32'd3; cti = 3'b000;
        @(negedge clk); check("b2b_req", ack, 1'b0);
        step();
        @(negedge clk); check("b2b_ack1", {ack, rdat}, {1'b1, model[0][3]});
        step();
        adr = 32'd4;
        @(negedge clk); check("b2b_gap", ack, 1'b0);
        step();
        @(negedge clk); check("b2b_ack2", {ack, rdat}, {1'b1, model[0][4]});
        step();
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk); check("b2b_end", ack, 1'b0);
        step();

        // Random mix of reads, writes, bursts and out-of-range starts
        for (int it = 0; it < 30; it++) begin
            d = $urandom_range(0, 2);
            n = $urandom_range(1, 4);
            w = 1'($urandom_range(0, 1));
            a = (d == 1) ? $urandom_range(0, 60) : $urandom_range(0, depth_t[d] + 2);
            for (int i = 0; i < 16; i++) begin
                bd[i] = $urandom; bs[i] = 4'($urandom_range(0, 15));
            end
            run_xfer(d, w, a, n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
